// File: rtl/dither_pkg.sv
// Shared state, neighbour and write-source encodings for the Floyd-Steinberg sequencer.
package dither_pkg;

   typedef enum logic [3:0] {
      IDLE, LOAD, PX_RD, PX_WR, NB_RD, NB_WR, ADV, UL_RD, UL_WAIT, FIN
   } seq_state_t;

   typedef enum logic [1:0] {NB_E, NB_SW, NB_S, NB_SE} nb_sel_t;

   typedef enum logic [1:0] {SRC_MCU, SRC_QUANT, SRC_DIFF} mem_src_t;

endpackage

// File: rtl/dither_nb_addr_gen.sv
// Planar pixel / neighbour address generator with edge-aware neighbour validity.
// Neighbours are visited in E, SW, S, SE order; x terms mirror when row_dir=1.
module dither_nb_addr_gen
   import dither_pkg::*;
#(
   parameter int IMAGEX   = 64,
   parameter int IMAGEY   = 64,
   parameter int CHANNELS = 1,
   parameter int ADDR_W   = $clog2(IMAGEX*IMAGEY*CHANNELS),
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   parameter int X_W      = $clog2(IMAGEX),
   parameter int Y_W      = $clog2(IMAGEY)
) (
   input  logic [X_W-1:0]    x,
   input  logic [Y_W-1:0]    y,
   input  logic [CH_W-1:0]   ch,
   input  logic              row_dir,
   input  nb_sel_t           sel,
   output logic [ADDR_W-1:0] pix_addr,
   output logic [ADDR_W-1:0] nb_addr,
   output logic              first_vld,
   output nb_sel_t           first_sel,
   output logic              next_vld,
   output nb_sel_t           next_sel
);

   localparam logic [ADDR_W-1:0] PLANE = ADDR_W'(IMAGEX*IMAGEY);
   localparam logic [ADDR_W-1:0] ROW   = ADDR_W'(IMAGEX);
   localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

   logic       x_first, x_last, y_last;
   logic [3:0] vld;

   // "first"/"last" are relative to the scan direction of the current row
   assign x_first = row_dir ? (x == X_W'(IMAGEX-1)) : (x == '0);
   assign x_last  = row_dir ? (x == '0) : (x == X_W'(IMAGEX-1));
   assign y_last  = (y == Y_W'(IMAGEY-1));

   assign vld = {!x_last && !y_last, !y_last, !x_first && !y_last, !x_last};

   assign pix_addr = ADDR_W'(ch) * PLANE + ADDR_W'(y) * ROW + ADDR_W'(x);

   always_comb begin
      nb_addr = pix_addr;
      case (sel)
         NB_E:    nb_addr = row_dir ? pix_addr - ONE : pix_addr + ONE;
         NB_SW:   nb_addr = row_dir ? pix_addr + ROW + ONE : pix_addr + ROW - ONE;
         NB_S:    nb_addr = pix_addr + ROW;
         default: nb_addr = row_dir ? pix_addr + ROW - ONE : pix_addr + ROW + ONE;
      endcase
   end

   // Downward scan so the lowest-index valid neighbour wins
   always_comb begin
      first_vld = 1'b0;
      first_sel = NB_E;
      next_vld  = 1'b0;
      next_sel  = NB_E;
      for (int i = 3; i >= 0; i--) begin
         if (vld[i]) begin
            first_vld = 1'b1;
            first_sel = nb_sel_t'(2'(i));
         end
         if (vld[i] && (i > int'(sel))) begin
            next_vld = 1'b1;
            next_sel = nb_sel_t'(2'(i));
         end
      end
   end

endmodule

// File: rtl/dither_seq_ctrl.sv
// Floyd-Steinberg sequencer: MCU load, per-pixel/channel quantise + neighbour RMW, MCU unload.
// Define DITHER_SERPENTINE_EN to alternate scan direction on every row.
module dither_seq_ctrl
   import dither_pkg::*;
#(
   parameter int IMAGEX   = 64,
   parameter int IMAGEY   = 64,
   parameter int CHANNELS = 1,
   parameter int ADDR_W   = $clog2(IMAGEX*IMAGEY*CHANNELS),
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rden,
   output logic              mem_wren,
   output logic [1:0]        mem_src,
   output logic [1:0]        nb_sel,
   output logic              err_latch,
   output logic [CH_W-1:0]   ch_idx,
   output logic              row_dir,
   output logic              busy,
   output logic              done
);

   localparam int X_W = $clog2(IMAGEX);
   localparam int Y_W = $clog2(IMAGEY);
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(IMAGEX*IMAGEY*CHANNELS-1);
   localparam logic [X_W-1:0]    X_MAX     = X_W'(IMAGEX-1);

   seq_state_t        state, state_nx;
   logic [X_W-1:0]    x, x_nx;
   logic [Y_W-1:0]    y, y_nx;
   logic [CH_W-1:0]   ch, ch_nx;
   logic              dir, dir_nx;
   logic [ADDR_W-1:0] word, word_nx;
   nb_sel_t           nb, nb_nx;

   logic [ADDR_W-1:0] pix_addr, nb_addr;
   logic              first_vld, next_vld;
   nb_sel_t           first_sel, next_sel;

   dither_nb_addr_gen #(
      .IMAGEX(IMAGEX), .IMAGEY(IMAGEY), .CHANNELS(CHANNELS),
      .ADDR_W(ADDR_W), .CH_W(CH_W), .X_W(X_W), .Y_W(Y_W)
   ) u_nb (
      .x(x), .y(y), .ch(ch), .row_dir(dir), .sel(nb),
      .pix_addr(pix_addr), .nb_addr(nb_addr),
      .first_vld(first_vld), .first_sel(first_sel),
      .next_vld(next_vld), .next_sel(next_sel)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         x     <= '0;
         y     <= '0;
         ch    <= '0;
         dir   <= 1'b0;
         word  <= '0;
         nb    <= NB_E;
      end else begin
         state <= state_nx;
         x     <= x_nx;
         y     <= y_nx;
         ch    <= ch_nx;
         dir   <= dir_nx;
         word  <= word_nx;
         nb    <= nb_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      x_nx      = x;
      y_nx      = y;
      ch_nx     = ch;
      dir_nx    = dir;
      word_nx   = word;
      nb_nx     = nb;
      tx_ready  = 1'b0;
      rx_valid  = 1'b0;
      mem_addr  = '0;
      mem_rden  = 1'b0;
      mem_wren  = 1'b0;
      mem_src   = SRC_MCU;
      nb_sel    = NB_E;
      err_latch = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) begin
            state_nx = LOAD;
            word_nx  = '0;
         end
         LOAD: begin
            tx_ready = 1'b1;
            mem_addr = word;
            if (tx_valid) begin
               mem_wren = 1'b1;
               if (word == LAST_WORD) begin
                  state_nx = PX_RD;
                  x_nx     = '0;
                  y_nx     = '0;
                  ch_nx    = '0;
                  dir_nx   = 1'b0;
               end else begin
                  word_nx = word + ADDR_W'(1);
               end
            end
         end
         PX_RD: begin
            mem_rden = 1'b1;
            mem_addr = pix_addr;
            state_nx = PX_WR;
         end
         PX_WR: begin
            mem_wren  = 1'b1;
            mem_src   = SRC_QUANT;
            err_latch = 1'b1;
            mem_addr  = pix_addr;
            if (first_vld) begin
               nb_nx    = first_sel;
               state_nx = NB_RD;
            end else begin
               state_nx = ADV;
            end
         end
         NB_RD: begin
            mem_rden = 1'b1;
            mem_addr = nb_addr;
            nb_sel   = nb;
            state_nx = NB_WR;
         end
         NB_WR: begin
            mem_wren = 1'b1;
            mem_src  = SRC_DIFF;
            mem_addr = nb_addr;
            nb_sel   = nb;
            if (next_vld) begin
               nb_nx    = next_sel;
               state_nx = NB_RD;
            end else begin
               state_nx = ADV;
            end
         end
         ADV: begin
            state_nx = PX_RD;
            if (ch != CH_W'(CHANNELS-1)) begin
               ch_nx = ch + CH_W'(1);
            end else begin
               ch_nx = '0;
               if (dir ? (x != '0) : (x != X_MAX)) begin
                  x_nx = dir ? x - X_W'(1) : x + X_W'(1);
               end else if (y == Y_W'(IMAGEY-1)) begin
                  state_nx = UL_RD;
                  word_nx  = '0;
                  x_nx     = '0;
                  y_nx     = '0;
                  dir_nx   = 1'b0;
               end else begin
                  y_nx = y + Y_W'(1);
`ifdef DITHER_SERPENTINE_EN
                  dir_nx = ~dir;
`endif
                  x_nx = dir_nx ? X_MAX : '0;
               end
            end
         end
         UL_RD: begin
            mem_rden = 1'b1;
            mem_addr = word;
            state_nx = UL_WAIT;
         end
         UL_WAIT: begin
            rx_valid = 1'b1;
            mem_addr = word;
            if (rx_ready) begin
               if (word == LAST_WORD) begin
                  state_nx = FIN;
               end else begin
                  word_nx  = word + ADDR_W'(1);
                  state_nx = UL_RD;
               end
            end
         end
         FIN: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy    = (state != IDLE);
   assign ch_idx  = ch;
   assign row_dir = dir;

endmodule

// File: tb/tb_dither_seq_ctrl.sv
// Directed bench for dither_seq_ctrl: a 4x2 gray instance and a 4x2 RGB instance,
// memory accesses checked against a coordinate-based scoreboard.
module tb_dither_seq_ctrl;

   localparam int X = 4;
   localparam int Y = 2;
`ifdef DITHER_SERPENTINE_EN
   localparam bit SERP = 1'b1;
`else
   localparam bit SERP = 1'b0;
`endif

   typedef struct packed {
      logic       rd;
      logic       wr;
      logic [1:0] src;
      logic [1:0] nb;
      logic       chk_nb;
      logic       dth;
      logic [1:0] mark;
      logic [4:0] addr;
      logic [1:0] ch;
      logic       dir;
   } acc_t;

   logic clk = 1'b0, rst = 1'b1, start0 = 1'b0, start1 = 1'b0;
   logic tx_valid = 1'b0, rx_ready = 1'b0;

   logic       tx_ready0, rx_valid0, rden0, wren0, err0, dir0, busy0, done0;
   logic [2:0] addr0;
   logic [1:0] src0, nb0;
   logic [0:0] ch0;
   logic       tx_ready1, rx_valid1, rden1, wren1, err1, dir1, busy1, done1;
   logic [4:0] addr1;
   logic [1:0] src1, nb1, ch1;

   int   n_assert = 0, n_fail = 0, cyc = 0;
   int   t_px0 = 0, t_ul0 = 0, t_px1 = 0, t_ul1 = 0, done_cnt0 = 0, done_cnt1 = 0;
   int   gen_cyc, exp_cyc0, exp_cyc1;
   acc_t q0[$], q1[$], gen_q[$];

   dither_seq_ctrl #(.IMAGEX(X), .IMAGEY(Y), .CHANNELS(1)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .tx_valid(tx_valid), .tx_ready(tx_ready0),
      .rx_valid(rx_valid0), .rx_ready(rx_ready), .mem_addr(addr0), .mem_rden(rden0),
      .mem_wren(wren0), .mem_src(src0), .nb_sel(nb0), .err_latch(err0), .ch_idx(ch0),
      .row_dir(dir0), .busy(busy0), .done(done0));

   dither_seq_ctrl #(.IMAGEX(X), .IMAGEY(Y), .CHANNELS(3)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .tx_valid(tx_valid), .tx_ready(tx_ready1),
      .rx_valid(rx_valid1), .rx_ready(rx_ready), .mem_addr(addr1), .mem_rden(rden1),
      .mem_wren(wren1), .mem_src(src1), .nb_sel(nb1), .err_latch(err1), .ch_idx(ch1),
      .row_dir(dir1), .busy(busy1), .done(done1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected access stream built from neighbour coordinates and bounds checks
   task automatic gen_frame(input int c_n);
      acc_t a;
      int   n, dir, dx, x, base, nx, ny;
      n = X*Y*c_n;
      gen_q.delete();
      gen_cyc = 0;
      for (int i = 0; i < n; i++) begin
         a = '0; a.wr = 1'b1; a.addr = 5'(i);
         gen_q.push_back(a);
      end
      for (int yy = 0; yy < Y; yy++) begin
         dir = SERP ? (yy % 2) : 0;
         dx  = (dir != 0) ? -1 : 1;
         for (int k = 0; k < X; k++) begin
            x = (dir != 0) ? X-1-k : k;
            for (int c = 0; c < c_n; c++) begin
               base = c*X*Y + yy*X + x;
               a = '0; a.dth = 1'b1; a.ch = 2'(c); a.dir = dir[0]; a.addr = 5'(base);
               a.rd = 1'b1; a.mark = (gen_q.size() == n) ? 2'd1 : 2'd0;
               gen_q.push_back(a);
               a.mark = 2'd0; a.rd = 1'b0; a.wr = 1'b1; a.src = 2'd1;
               gen_q.push_back(a);
               gen_cyc += 3;
               for (int j = 0; j < 4; j++) begin
                  nx = (j == 0 || j == 3) ? x + dx : (j == 1) ? x - dx : x;
                  ny = (j == 0) ? yy : yy + 1;
                  if (nx >= 0 && nx < X && ny < Y) begin
                     a.addr = 5'(c*X*Y + ny*X + nx); a.nb = 2'(j); a.chk_nb = 1'b1;
                     a.rd = 1'b1; a.wr = 1'b0; a.src = 2'd0; gen_q.push_back(a);
                     a.rd = 1'b0; a.wr = 1'b1; a.src = 2'd2; gen_q.push_back(a);
                     gen_cyc += 2;
                  end
               end
            end
         end
      end
      for (int i = 0; i < n; i++) begin
         a = '0; a.rd = 1'b1; a.addr = 5'(i); a.mark = (i == 0) ? 2'd2 : 2'd0;
         gen_q.push_back(a);
      end
   endtask

   always @(negedge clk) begin
      acc_t e;
      if (rden0 || wren0) begin
         chk("rd_wr_excl0", 32'(rden0 & wren0), 32'd0);
         if (q0.size() == 0) chk("q0_underflow", 32'(q0.size()), 32'd1);
         else begin
            e = q0.pop_front();
            chk("rden0", 32'(rden0), 32'(e.rd));
            chk("addr0", 32'(addr0), 32'(e.addr));
            chk("err_latch0", 32'(err0), 32'(e.wr && e.src == 2'd1));
            if (e.wr) chk("src0", 32'(src0), 32'(e.src));
            if (e.chk_nb) chk("nb_sel0", 32'(nb0), 32'(e.nb));
            if (e.dth) begin
               chk("ch0", 32'(ch0), 32'(e.ch));
               chk("row_dir0", 32'(dir0), 32'(e.dir));
            end
            if (e.mark == 2'd1) t_px0 = cyc;
            if (e.mark == 2'd2) t_ul0 = cyc;
         end
      end
      if (done0) done_cnt0++;
   end

   always @(negedge clk) begin
      acc_t e;
      if (rden1 || wren1) begin
         chk("rd_wr_excl1", 32'(rden1 & wren1), 32'd0);
         if (q1.size() == 0) chk("q1_underflow", 32'(q1.size()), 32'd1);
         else begin
            e = q1.pop_front();
            chk("rden1", 32'(rden1), 32'(e.rd));
            chk("addr1", 32'(addr1), 32'(e.addr));
            chk("err_latch1", 32'(err1), 32'(e.wr && e.src == 2'd1));
            if (e.wr) chk("src1", 32'(src1), 32'(e.src));
            if (e.chk_nb) chk("nb_sel1", 32'(nb1), 32'(e.nb));
            if (e.dth) begin
               chk("ch1", 32'(ch1), 32'(e.ch));
               chk("row_dir1", 32'(dir1), 32'(e.dir));
            end
            if (e.mark == 2'd1) t_px1 = cyc;
            if (e.mark == 2'd2) t_ul1 = cyc;
         end
      end
      if (done1) done_cnt1++;
   end

   task automatic pulse_start(input int sel);
      @(posedge clk); #1;
      if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic load(input int sel, input int n, input bit gap);
      int cnt = 0, k = 0;
      while (cnt < n && k < 400) begin
         @(posedge clk); #1;
         tx_valid = gap ? k[0] : 1'b1;
         @(negedge clk);
         if (tx_valid && ((sel != 0) ? tx_ready1 : tx_ready0)) cnt++;
         k++;
      end
      chk("load_words", 32'(cnt), 32'(n));
      @(posedge clk); #1;
      tx_valid = 1'b0;
      @(negedge clk);
      chk("tx_ready_after_load", 32'((sel != 0) ? tx_ready1 : tx_ready0), 32'd0);
   endtask

   task automatic unload(input int sel, input bit hold);
      int k = 0;
      logic [4:0] a_hold;
      rx_ready = 1'b0;
      while (!((sel != 0) ? rx_valid1 : rx_valid0) && k < 2000) begin
         @(negedge clk); k++;
      end
      chk("rx_valid_seen", 32'((sel != 0) ? rx_valid1 : rx_valid0), 32'd1);
      if (hold) begin
         a_hold = 5'(addr0);
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rx_valid", 32'(rx_valid0), 32'd1);
            chk("hold_addr", 32'(addr0), 32'(a_hold));
            chk("hold_no_rden", 32'(rden0), 32'd0);
         end
      end
      @(posedge clk); #1;
      rx_ready = 1'b1;
      k = 0;
      while (!((sel != 0) ? done1 : done0) && k < 500) begin
         @(negedge clk); k++;
      end
      chk("done_seen", 32'((sel != 0) ? done1 : done0), 32'd1);
      chk("busy_at_done", 32'((sel != 0) ? busy1 : busy0), 32'd1);
      @(negedge clk);
      chk("busy_after_done", 32'((sel != 0) ? busy1 : busy0), 32'd0);
      chk("done_one_cycle", 32'((sel != 0) ? done1 : done0), 32'd0);
      @(posedge clk); #1;
      rx_ready = 1'b0;
   endtask

   initial begin
      int k;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready0), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid0), 32'd0);
      chk("rst_addr", 32'(addr0), 32'd0);
      chk("rst_rden", 32'(rden0), 32'd0);
      chk("rst_wren", 32'(wren0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_row_dir", 32'(dir0), 32'd0);
      chk("rst_ch", 32'(ch1), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // abort in the middle of a neighbour write
      gen_frame(1);
      q0 = gen_q;
      pulse_start(0);
      load(0, X*Y, 1'b0);
      k = 0;
      while (!(wren0 && src0 == 2'd2) && k < 100) begin
         @(negedge clk); k++;
      end
      chk("reach_nb_wr", 32'(wren0 && src0 == 2'd2), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy0), 32'd0);
      chk("abort_wren", 32'(wren0), 32'd0);
      chk("abort_src", 32'(src0), 32'd0);
      chk("abort_addr", 32'(addr0), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      q0.delete();

      // full gray frame, sparse load, stalled first unload word
      gen_frame(1);
      q0 = gen_q;
      exp_cyc0 = gen_cyc;
      pulse_start(0);
      load(0, X*Y, 1'b1);
      unload(0, 1'b1);
      chk("dither_cycles0", 32'(t_ul0 - t_px0), 32'(exp_cyc0));
      chk("done_once0", 32'(done_cnt0), 32'd1);
      chk("q0_drained", 32'(q0.size()), 32'd0);

      // three-plane frame
      gen_frame(3);
      q1 = gen_q;
      exp_cyc1 = gen_cyc;
      pulse_start(1);
      load(1, X*Y*3, 1'b0);
      unload(1, 1'b0);
      chk("dither_cycles1", 32'(t_ul1 - t_px1), 32'(exp_cyc1));
      chk("done_once1", 32'(done_cnt1), 32'd1);
      chk("q1_drained", 32'(q1.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
